// File: rtl/matproc_pkg.sv
// Shared types and sizing helpers for the matrix stream engine.
// Holds the controller state encoding and the accumulator width rule.
// Imported by the engine top and every MAC lane.
package matproc_pkg;

  // Controller states, fixed binary encoding
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_MAT = 3'd1,
    LOAD_VEC = 3'd2,
    ROUND    = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Accumulator width: full signed product plus headroom for DIM additions
  function automatic int acc_width(input int width, input int dim);
    return 2 * width + $clog2(dim);
  endfunction

endpackage

// File: rtl/matrix_mac_lane.sv
// One matrix row accumulator: clear, signed multiply-accumulate, round/saturate.
// Latency: accumulate lands one cycle after acc_en_i; out_o is combinational from acc.
// Backpressure: none; the controller decides when clr_i/acc_en_i fire.
module matrix_mac_lane
  import matproc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIM   = 4,
  parameter int FRAC  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             acc_en_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] v_i,
  output logic [WIDTH-1:0] out_o
);

  localparam int AW = acc_width(WIDTH, DIM);
  localparam logic signed [AW-1:0] MAX_V = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      acc_q;
  logic signed [AW-1:0]      acc_d;
  logic signed [AW-1:0]      shifted;

  // Full-width signed product, sign-extended into the accumulator
  always_comb begin
    prod  = $signed(m_i) * $signed(v_i);
    acc_d = acc_q + AW'(prod);
  end

  // Accumulator register: cleared per vector, updated on each returned element
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q <= '0;
    end else if (acc_en_i) begin
      acc_q <= acc_d;
    end
  end

  // Drop fraction bits (floor) and clamp to the signed output range
  always_comb begin
    shifted = acc_q >>> FRAC;
    if (shifted > MAX_V) begin
      out_o = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      out_o = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      out_o = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/matrix_stream_engine.sv
// Loads a DIMxDIM matrix once, then streams vectors through it: out = round(M*v).
// Latency per vector: DIM reads, one round cycle, DIM writes, all handshake-paced.
// Backpressure: rdReq/wrEn hold address and data stable until rdValid/wrReady.
module matrix_stream_engine
  import matproc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIM     = 4,
  parameter int FRAC    = 16,
  parameter int COUNT_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] workItemCount,
  input  logic [WIDTH-1:0]   matrixInAddr,
  input  logic [WIDTH-1:0]   dataInAddr,
  input  logic [WIDTH-1:0]   dataOutAddr,
  output logic               rdReq,
  output logic [WIDTH-1:0]   rdAddr,
  input  logic               rdValid,
  input  logic [WIDTH-1:0]   rdData,
  output logic               wrEn,
  output logic [WIDTH-1:0]   wrAddr,
  output logic [WIDTH-1:0]   wrData,
  input  logic               wrReady,
  output logic               busy,
  output logic               done
);

  localparam int IW = $clog2(DIM * DIM);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(WIDTH / 8);
  localparam logic [IW-1:0]    MAT_LAST = IW'(DIM * DIM - 1);
  localparam logic [IW-1:0]    VEC_LAST = IW'(DIM - 1);

  state_e             state_q;
  logic [COUNT_W-1:0] count_q, k_q;
  logic [IW-1:0]      idx_q;
  logic [WIDTH-1:0]   vec_ptr_q, out_ptr_q;
  logic               rdReq_q, wrEn_q, busy_q, done_q;
  logic [WIDTH-1:0]   rdAddr_q, wrAddr_q, wrData_q;
  logic [WIDTH-1:0]   mat_q [DIM*DIM];

  logic             rd_fire, wr_fire, more_work, lane_clr, lane_acc;
  logic [WIDTH-1:0] m_col    [DIM];
  logic [WIDTH-1:0] lane_out [DIM];
  logic [WIDTH-1:0] next_out;

  assign rdReq  = rdReq_q;
  assign rdAddr = rdAddr_q;
  assign wrEn   = wrEn_q;
  assign wrAddr = wrAddr_q;
  assign wrData = wrData_q;
  assign busy   = busy_q;
  assign done   = done_q;

  assign rd_fire   = rdReq_q && rdValid;
  assign wr_fire   = wrEn_q && wrReady;
  assign more_work = ((COUNT_W+1)'(k_q) + (COUNT_W+1)'(1)) < (COUNT_W+1)'(count_q);
  // Clear on entry to every vector; accumulate on each returned element
  assign lane_clr  = (state_q == LOAD_MAT && rd_fire && idx_q == MAT_LAST) ||
                     (state_q == WRITE && wr_fire && idx_q == VEC_LAST && more_work);
  assign lane_acc  = (state_q == LOAD_VEC) && rd_fire;

  // Column j of the matrix feeds the lanes; pick the next output for the write stream
  always_comb begin
    next_out = '0;
    for (int i = 0; i < DIM; i++) begin
      m_col[i] = '0;
      for (int j = 0; j < DIM; j++) begin
        if (IW'(j) == idx_q) m_col[i] = mat_q[i*DIM + j];
      end
      if (IW'(i) == idx_q + IW'(1)) next_out = lane_out[i];
    end
  end

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    matrix_mac_lane #(.WIDTH(WIDTH), .DIM(DIM), .FRAC(FRAC)) u_lane (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (lane_clr),
      .acc_en_i(lane_acc),
      .m_i     (m_col[g]),
      .v_i     (rdData),
      .out_o   (lane_out[g])
    );
  end

  // Matrix storage, row-major, captured during LOAD_MAT (no reset needed)
  always_ff @(posedge clk) begin
    if (state_q == LOAD_MAT && rd_fire) begin
      for (int n = 0; n < DIM*DIM; n++) begin
        if (IW'(n) == idx_q) mat_q[n] <= rdData;
      end
    end
  end

  // Controller FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      k_q       <= '0;
      idx_q     <= '0;
      vec_ptr_q <= '0;
      out_ptr_q <= '0;
      rdReq_q   <= 1'b0;
      rdAddr_q  <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q   <= workItemCount;
            k_q       <= '0;
            idx_q     <= '0;
            vec_ptr_q <= dataInAddr;
            out_ptr_q <= dataOutAddr;
            busy_q    <= 1'b1;
            if (workItemCount == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= LOAD_MAT;
              rdReq_q  <= 1'b1;
              rdAddr_q <= matrixInAddr;
            end
          end
        end
        LOAD_MAT: begin
          if (rd_fire) begin
            if (idx_q == MAT_LAST) begin
              idx_q    <= '0;
              rdAddr_q <= vec_ptr_q;
              state_q  <= LOAD_VEC;
            end else begin
              idx_q    <= idx_q + IW'(1);
              rdAddr_q <= rdAddr_q + STEP;
            end
          end
        end
        LOAD_VEC: begin
          if (rd_fire) begin
            vec_ptr_q <= vec_ptr_q + STEP;
            if (idx_q == VEC_LAST) begin
              idx_q   <= '0;
              rdReq_q <= 1'b0;
              state_q <= ROUND;
            end else begin
              idx_q    <= idx_q + IW'(1);
              rdAddr_q <= vec_ptr_q + STEP;
            end
          end
        end
        ROUND: begin
          wrEn_q   <= 1'b1;
          wrAddr_q <= out_ptr_q;
          wrData_q <= lane_out[0];
          state_q  <= WRITE;
        end
        WRITE: begin
          if (wr_fire) begin
            out_ptr_q <= out_ptr_q + STEP;
            if (idx_q == VEC_LAST) begin
              idx_q  <= '0;
              wrEn_q <= 1'b0;
              if (more_work) begin
                k_q      <= k_q + COUNT_W'(1);
                rdReq_q  <= 1'b1;
                rdAddr_q <= vec_ptr_q;
                state_q  <= LOAD_VEC;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else begin
              idx_q    <= idx_q + IW'(1);
              wrAddr_q <= out_ptr_q + STEP;
              wrData_q <= next_out;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
